// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave oversampled in the clk_i domain; decodes command words into write registers
// and returns a selected read port on SDO, one word behind the command stream.
module spi_reg_bridge #(
   parameter int  WORD_SIZE  = 16,
   parameter int  ADDR_WIDTH = 3,
   parameter int  NUM_REGS   = 4,
   parameter int  NUM_RD     = 4,
   localparam int DATA_W     = WORD_SIZE - 1 - ADDR_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       spi_sck_i,
   input  logic                       spi_sdi_i,
   input  logic                       spi_cs_i,
   output logic                       spi_sdo_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic [NUM_REGS-1:0]        wr_stb_o,
   input  logic [NUM_RD*DATA_W-1:0]   rd_data_i,
   output logic                       frame_err_o
);
   localparam int               CNT_W    = $clog2(WORD_SIZE);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

   typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      sck_sync_q, sdi_sync_q, cs_sync_q;
   logic                            sck_prev_q;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]            rx_q, rx_d, tx_q, tx_d;
   logic                            done_q, done_d;
   logic                            err_q, err_d;
   logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]             stb_q, stb_d;
   logic [NUM_RD-1:0][DATA_W-1:0]   rd_arr;
   logic [DATA_W-1:0]               rd_sel;
   logic [WORD_SIZE-1:0]            tx_word;
   logic                            sck_s, sdi_s, cs_s, sck_rise, sck_fall;
   logic [ADDR_WIDTH-1:0]           rx_addr;

   assign sck_s    = sck_sync_q[1];
   assign sdi_s    = sdi_sync_q[1];
   assign cs_s     = cs_sync_q[1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign rd_arr   = rd_data_i;
   assign rx_addr  = rx_q[WORD_SIZE-2 -: ADDR_WIDTH];

   // Completed word is acted on one cycle after its last bit lands in rx_q.
   always_comb begin
      ptr_d  = ptr_q;
      regs_d = regs_q;
      stb_d  = '0;
      if (done_q) begin
         ptr_d = rx_addr;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_q[WORD_SIZE-1] && rx_addr == ADDR_WIDTH'(k)) begin
               regs_d[k] = rx_q[DATA_W-1:0];
               stb_d[k]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (ptr_d == ADDR_WIDTH'(i)) rd_sel = rd_arr[i];
      end
   end

   assign tx_word = {1'b0, ptr_d, rd_sel};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         RESYNC: if (cs_s) state_d = IDLE;
         IDLE: begin
            if (!cs_s) begin
               state_d = SHIFT;
               cnt_d   = '0;
               tx_d    = tx_word;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               rx_d = {rx_q[WORD_SIZE-2:0], sdi_s};
               if (cnt_q == LAST_BIT) begin
                  cnt_d  = '0;
                  done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // The fall right after a word boundary must keep the freshly reloaded MSB.
            if (sck_fall && cnt_q != '0) tx_d = {tx_q[WORD_SIZE-2:0], 1'b0};
            if (done_q) tx_d = tx_word;
            if (cs_s) begin
               state_d = IDLE;
               if (cnt_d != '0) err_d = 1'b1;
               cnt_d = '0;
            end
         end
         default: state_d = RESYNC;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         // cs sync clears low so RESYNC waits for a genuine CS-high before accepting a frame.
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         cs_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         state_q    <= RESYNC;
         cnt_q      <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ptr_q      <= '0;
         regs_q     <= '0;
         stb_q      <= '0;
      end else begin
         sck_sync_q <= {sck_sync_q[0], spi_sck_i};
         sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
         cs_sync_q  <= {cs_sync_q[0], spi_cs_i};
         sck_prev_q <= sck_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ptr_q      <= ptr_d;
         regs_q     <= regs_d;
         stb_q      <= stb_d;
      end
   end

   assign spi_sdo_o   = (state_q == SHIFT) & tx_q[WORD_SIZE-1];
   assign regs_o      = regs_q;
   assign wr_stb_o    = stb_q;
   assign frame_err_o = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: bit-banged SPI master at clk/8 against a register-map model.
module tb_spi_reg_bridge;
   logic              clk = 1'b0;
   logic              reset_i = 1'b1;
   logic              spi_sck = 1'b0, spi_sdi = 1'b0, spi_cs = 1'b1;
   logic              spi_sdo_o;
   logic [47:0]       regs_o;
   logic [3:0]        wr_stb_o;
   logic [3:0][11:0]  rd_data;
   logic              frame_err_o;

   logic [3:0][11:0]  m_regs;
   logic [2:0]        m_ptr;
   logic              m_err;
   int                m_stb [4];
   int                stb_cnt [4];
   int                stb_dbl = 0;
   logic [3:0]        prev_stb = '0;
   int                cyc = 0, last_rise_cyc = 0, last_stb_cyc = 0;
   int                n_chk = 0, n_fail = 0;

   spi_reg_bridge dut (
      .clk_i(clk), .reset_i(reset_i), .spi_sck_i(spi_sck), .spi_sdi_i(spi_sdi),
      .spi_cs_i(spi_cs), .spi_sdo_o(spi_sdo_o), .regs_o(regs_o), .wr_stb_o(wr_stb_o),
      .rd_data_i(rd_data), .frame_err_o(frame_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) if (wr_stb_o[k]) stb_cnt[k]++;
      if ((wr_stb_o & prev_stb) != 4'b0) stb_dbl++;
      if (|wr_stb_o) last_stb_cyc = cyc;
      prev_stb = wr_stb_o;
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_regs = '0; m_ptr = '0; m_err = 1'b0;
      for (int k = 0; k < 4; k++) begin m_stb[k] = 0; stb_cnt[k] = 0; end
   endtask

   function automatic logic [15:0] exp_tx();
      logic [11:0] d;
      d = (m_ptr < 3'd4) ? rd_data[m_ptr[1:0]] : 12'h000;
      return {1'b0, m_ptr, d};
   endfunction

   task automatic model_word(input logic [15:0] w);
      if (w[15] && w[14:12] < 3'd4) begin
         m_regs[w[13:12]] = w[11:0];
         m_stb[w[13:12]]++;
      end
      m_ptr = w[14:12];
   endtask

   // ---------------- SPI master ----------------
   task automatic spi_bits(input logic [15:0] w, input int from, input int to,
                           output logic [15:0] rsp);
      rsp = '0;
      for (int i = from; i < to; i++) begin
         @(negedge clk) spi_sdi = w[15-i];
         repeat (3) @(negedge clk);
         rsp[15-i] = spi_sdo_o;
         spi_sck = 1'b1;
         last_rise_cyc = cyc;
         repeat (4) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_start();
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (8) @(negedge clk);
      spi_cs = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      repeat (4) @(negedge clk);
      reset_i = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      spi_cs = 1'b1; spi_sck = 1'b0;
      do_reset();
      n_chk++; if (regs_o !== 48'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs_o); end
      n_chk++; if (wr_stb_o !== 4'h0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", wr_stb_o); end
      n_chk++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err_o); end
      n_chk++; if (spi_sdo_o !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", spi_sdo_o); end
   endtask

   task automatic test_write();
      logic [15:0] rsp, exp;
      cs_start();
      exp = exp_tx();
      spi_bits(16'hAABC, 0, 16, rsp);
      model_word(16'hAABC);
      cs_end();
      n_chk++; if (rsp !== exp) begin n_fail++; $display("FAIL write_rsp: got %h want %h", rsp, exp); end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL write_regs: got %h want %h", regs_o, m_regs); end
      n_chk++; if (regs_o[35:24] !== 12'hABC) begin n_fail++; $display("FAIL write_reg2: got %h want abc", regs_o[35:24]); end
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (stb_cnt[k] !== m_stb[k]) begin n_fail++; $display("FAIL write_stb%0d: got %0d want %0d", k, stb_cnt[k], m_stb[k]); end
      end
      n_chk++; if (last_stb_cyc - last_rise_cyc !== 4) begin n_fail++; $display("FAIL write_latency: got %0d want 4", last_stb_cyc - last_rise_cyc); end
      n_chk++; if (stb_dbl !== 0) begin n_fail++; $display("FAIL write_stb_width: got %0d wide pulses want 0", stb_dbl); end
   endtask

   task automatic test_read();
      logic [15:0] rsp;
      rd_data[1] = 12'h5A5;
      cs_start(); spi_bits(16'h1000, 0, 16, rsp); model_word(16'h1000); cs_end();
      cs_start(); spi_bits(16'h0000, 0, 16, rsp); model_word(16'h0000); cs_end();
      n_chk++; if (rsp !== 16'h15A5) begin n_fail++; $display("FAIL read_rsp: got %h want 15a5", rsp); end
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (stb_cnt[k] !== m_stb[k]) begin n_fail++; $display("FAIL read_stb%0d: got %0d want %0d", k, stb_cnt[k], m_stb[k]); end
      end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL read_regs: got %h want %h", regs_o, m_regs); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [3];
      logic [15:0] rsp, exp;
      w[0] = 16'h8123; w[1] = 16'h9456; w[2] = 16'h1000;
      cs_start();
      for (int i = 0; i < 3; i++) begin
         exp = exp_tx();
         spi_bits(w[i], 0, 16, rsp);
         model_word(w[i]);
         n_chk++; if (rsp !== exp) begin n_fail++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp, exp); end
      end
      cs_end();
      n_chk++; if (regs_o[11:0] !== 12'h123 || regs_o[23:12] !== 12'h456) begin
         n_fail++; $display("FAIL b2b_regs: got %h want reg0=123 reg1=456", regs_o); end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL b2b_all_regs: got %h want %h", regs_o, m_regs); end
      n_chk++; if (stb_dbl !== 0) begin n_fail++; $display("FAIL b2b_stb_width: got %0d want 0", stb_dbl); end
   endtask

   task automatic test_frame_err();
      logic [15:0] rsp, exp;
      cs_start(); spi_bits(16'hB777, 0, 9, rsp); cs_end();
      m_err = 1'b1;
      n_chk++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", frame_err_o); end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL ferr_regs: got %h want %h", regs_o, m_regs); end
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (stb_cnt[k] !== m_stb[k]) begin n_fail++; $display("FAIL ferr_stb%0d: got %0d want %0d", k, stb_cnt[k], m_stb[k]); end
      end
      cs_start(); exp = exp_tx(); spi_bits(16'hA0F0, 0, 16, rsp); model_word(16'hA0F0); cs_end();
      n_chk++; if (rsp !== exp) begin n_fail++; $display("FAIL ferr_next_rsp: got %h want %h", rsp, exp); end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL ferr_next_regs: got %h want %h", regs_o, m_regs); end
      n_chk++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", frame_err_o); end
   endtask

   task automatic test_bad_addr();
      logic [15:0] rsp;
      cs_start(); spi_bits(16'hF00F, 0, 16, rsp); model_word(16'hF00F); cs_end();
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL badaddr_regs: got %h want %h", regs_o, m_regs); end
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (stb_cnt[k] !== m_stb[k]) begin n_fail++; $display("FAIL badaddr_stb%0d: got %0d want %0d", k, stb_cnt[k], m_stb[k]); end
      end
      cs_start(); spi_bits(16'h0000, 0, 16, rsp); model_word(16'h0000); cs_end();
      n_chk++; if (rsp !== 16'h7000) begin n_fail++; $display("FAIL badaddr_rsp: got %h want 7000", rsp); end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] rsp, exp;
      cs_start();
      spi_bits(16'hAABC, 0, 6, rsp);
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      model_reset();
      spi_bits(16'hAABC, 6, 16, rsp);
      cs_end();
      n_chk++; if (regs_o !== 48'h0) begin n_fail++; $display("FAIL rstmid_regs: got %h want 0", regs_o); end
      n_chk++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", frame_err_o); end
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (stb_cnt[k] !== 0) begin n_fail++; $display("FAIL rstmid_stb%0d: got %0d want 0", k, stb_cnt[k]); end
      end
      cs_start(); exp = exp_tx(); spi_bits(16'hAABC, 0, 16, rsp); model_word(16'hAABC); cs_end();
      n_chk++; if (rsp !== exp) begin n_fail++; $display("FAIL rstmid_next_rsp: got %h want %h", rsp, exp); end
      n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL rstmid_next_regs: got %h want %h", regs_o, m_regs); end
      n_chk++; if (stb_cnt[2] !== 1) begin n_fail++; $display("FAIL rstmid_next_stb: got %0d want 1", stb_cnt[2]); end
   endtask

   task automatic test_random();
      logic [15:0] w, rsp, exp;
      int nw;
      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < 4; k++) rd_data[k] = 12'($urandom);
         nw = $urandom_range(1, 3);
         cs_start();
         for (int i = 0; i < nw; i++) begin
            w = 16'($urandom);
            exp = exp_tx();
            spi_bits(w, 0, 16, rsp);
            model_word(w);
            n_chk++; if (rsp !== exp) begin n_fail++; $display("FAIL rand_rsp f%0d w%0d: got %h want %h (word %h)", f, i, rsp, exp, w); end
         end
         cs_end();
         n_chk++; if (regs_o !== m_regs) begin n_fail++; $display("FAIL rand_regs f%0d: got %h want %h", f, regs_o, m_regs); end
         for (int k = 0; k < 4; k++) begin
            n_chk++; if (stb_cnt[k] !== m_stb[k]) begin n_fail++; $display("FAIL rand_stb%0d f%0d: got %0d want %0d", k, f, stb_cnt[k], m_stb[k]); end
         end
         n_chk++; if (frame_err_o !== m_err) begin n_fail++; $display("FAIL rand_err f%0d: got %b want %b", f, frame_err_o, m_err); end
      end
      n_chk++; if (stb_dbl !== 0) begin n_fail++; $display("FAIL rand_stb_width: got %0d want 0", stb_dbl); end
   endtask

   initial begin
      rd_data = {12'h321, 12'h0F0, 12'h777, 12'h1E4};
      model_reset();
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_frame_err();
      test_bad_addr();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
